// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//
// Round-robin arbiter and watchdog for the shared 32-bit system bus.
// Eight DMA masters raise level-sensitive requests. One master at a time
// receives a registered one-hot grant. Between owners there is always a
// two-cycle all-zero grant window so the bus can turn around. An owner that
// holds the bus too long while others wait is preempted, but only between
// transactions. A transaction whose slave never answers is aborted.
//
// Transaction handshake: while granted, the owner holds `request` high for
// the whole transaction. The addressed slave raises `ready` for the cycle in
// which the transaction completes. A cycle with request=1 and ready=0 is a
// stall cycle. A grant is never removed while request=1, except when the
// stall count reaches TIMEOUT.
//
// Parameters:
//   TIMEOUT   consecutive stall cycles before an abort (2..255)
//   HOLD_MAX  owned cycles before preemption when others wait (1..255)
//
// Ports:
//   clk        bus clock, rising edge
//   rst_n      asynchronous active-low reset
//   dma_req    [7:0] per-master bus request, bit i = master i
//   request    transaction strobe from the granted master
//   ready      transaction complete from the addressed slave
//   grant      [7:0] one-hot grant or zero, registered
//   owner      [2:0] current owner index, meaningful while bus_busy=1
//   bus_busy   high while a master owns the bus
//   bus_error  one-cycle pulse after a timeout abort
//   err_owner  [2:0] master aborted by the most recent timeout (sticky)
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned HOLD_MAX = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] dma_req,
   input  logic       request,
   input  logic       ready,
   output logic [7:0] grant,
   output logic [2:0] owner,
   output logic       bus_busy,
   output logic       bus_error,
   output logic [2:0] err_owner
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_OWNED = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_ERROR = 2'd3;

   // Counter values at which the timeout and preemption rules fire.
   localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [1:0] state;
   logic [2:0] last_owner;
   logic [7:0] hold_cnt;
   logic [7:0] wd_cnt;

   // Round-robin pick: the first set request bit found after last_owner,
   // wrapping modulo 8. Offset 8 wraps back to last_owner itself, so that
   // master is chosen only when it is the sole requester.
   logic [2:0] sel;
   logic [2:0] cand;
   logic       sel_found;

   always_comb begin
      sel       = 3'd0;
      cand      = 3'd0;
      sel_found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cand = last_owner + 3'(i);
         if (!sel_found && dma_req[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
      end
   end

   logic stall;
   logic timeout_hit;
   logic release_hit;
   logic preempt_hit;

   assign stall       = request & ~ready;
   assign timeout_hit = stall && (wd_cnt == WD_LAST);
   assign release_hit = !dma_req[owner] && !request;
   assign preempt_hit = (hold_cnt >= HOLD_LAST) && ((dma_req & ~grant) != 8'd0) && !request;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         grant      <= 8'd0;
         owner      <= 3'd0;
         bus_busy   <= 1'b0;
         bus_error  <= 1'b0;
         err_owner  <= 3'd0;
         last_owner <= 3'd7;
         hold_cnt   <= 8'd0;
         wd_cnt     <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               grant <= 8'd0;
               if (sel_found) begin
                  grant      <= 8'd1 << sel;
                  owner      <= sel;
                  last_owner <= sel;
                  hold_cnt   <= 8'd0;
                  wd_cnt     <= 8'd0;
                  bus_busy   <= 1'b1;
                  state      <= S_OWNED;
               end
            end
            S_OWNED: begin
               if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
               wd_cnt <= stall ? wd_cnt + 8'd1 : 8'd0;
               // Timeout outranks the other exits. Release and preemption
               // both need request=0, so neither one can cut a transaction.
               if (timeout_hit) begin
                  grant     <= 8'd0;
                  bus_busy  <= 1'b0;
                  bus_error <= 1'b1;
                  err_owner <= owner;
                  state     <= S_ERROR;
               end else if (release_hit || preempt_hit) begin
                  grant    <= 8'd0;
                  bus_busy <= 1'b0;
                  state    <= S_GAP;
               end
            end
            S_GAP: begin
               grant <= 8'd0;
               state <= S_IDLE;
            end
            S_ERROR: begin
               grant     <= 8'd0;
               bus_error <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               grant     <= 8'd0;
               bus_busy  <= 1'b0;
               bus_error <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
//
// Self-checking bench for bus_arbiter_rr (TIMEOUT=16, HOLD_MAX=4).
// A reference model sits beside the DUT. It tracks who owns the bus, how
// many cycles that owner has held it, how many consecutive stall cycles have
// passed, and how many dead cycles must pass before the next arbitration.
// The model is stepped on every rising edge, and all outputs are compared on
// the following falling edge. The directed scenarios also check constant
// expected values, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;

   localparam int T_OUT = 16;
   localparam int H_MAX = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] dma_req = 8'd0;
   logic       request = 1'b0;
   logic       ready = 1'b0;
   logic [7:0] grant;
   logic [2:0] owner;
   logic       bus_busy;
   logic       bus_error;
   logic [2:0] err_owner;

   int checks = 0;
   int passes = 0;

   bus_arbiter_rr #(.TIMEOUT(T_OUT), .HOLD_MAX(H_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dma_req   (dma_req),
      .request   (request),
      .ready     (ready),
      .grant     (grant),
      .owner     (owner),
      .bus_busy  (bus_busy),
      .bus_error (bus_error),
      .err_owner (err_owner)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_owner;      // -1 when nobody owns the bus
   int m_last;       // most recent owner, used as the round-robin pointer
   int m_held;       // owned cycles counted so far, including this edge
   int m_stall;      // consecutive stall cycles
   int m_cool;       // dead edges still to pass before arbitration
   bit m_err;
   int m_err_owner;

   task automatic model_reset();
      m_owner     = -1;
      m_last      = 7;
      m_held      = 0;
      m_stall     = 0;
      m_cool      = 0;
      m_err       = 1'b0;
      m_err_owner = 0;
   endtask

   task automatic model_edge();
      int pick;
      int m;
      logic [7:0] others;
      m_err = 1'b0;
      if (m_cool > 0) begin
         m_cool--;
      end else if (m_owner < 0) begin
         pick = -1;
         for (int k = 1; k <= 8; k++) begin
            m = (m_last + k) % 8;
            if (pick < 0 && dma_req[m]) pick = m;
         end
         if (pick >= 0) begin
            m_owner = pick;
            m_last  = pick;
            m_held  = 0;
            m_stall = 0;
         end
      end else begin
         m_held  = (m_held < 255) ? m_held + 1 : 255;
         m_stall = (request && !ready) ? m_stall + 1 : 0;
         others  = dma_req & ~(8'd1 << m_owner);
         if (m_stall >= T_OUT) begin
            m_err       = 1'b1;
            m_err_owner = m_owner;
            m_owner     = -1;
            m_cool      = 1;
         end else if (!request && (!dma_req[m_owner] || (m_held >= H_MAX && others != 0))) begin
            m_owner = -1;
            m_cool  = 1;
         end
      end
   endtask

   function automatic logic [7:0] exp_grant();
      return (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_model();
      check("grant", 32'(grant), 32'(exp_grant()));
      check("bus_busy", 32'(bus_busy), 32'(m_owner >= 0));
      if (m_owner >= 0) check("owner", 32'(owner), 32'(m_owner));
      check("bus_error", 32'(bus_error), 32'(m_err));
      check("err_owner", 32'(err_owner), 32'(m_err_owner));
      check("onehot0", 32'($onehot0(grant)), 32'd1);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      dma_req = 8'd0;
      request = 1'b0;
      ready   = 1'b0;
      #1;
      model_reset();
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input int budget);
      for (int k = 0; k < budget && grant == 8'd0; k++) step();
      check("wait_grant_budget", 32'(grant != 8'd0), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int zeros;
      int mode;
      model_reset();
      #2;

      // Reset, single grant to master 0, release, GAP and IDLE.
      apply_reset();
      check("rst_grant", 32'(grant), 32'h00);
      check("rst_busy", 32'(bus_busy), 32'd0);
      dma_req = 8'h01;
      step();
      check("t1_grant", 32'(grant), 32'h01);
      check("t1_owner", 32'(owner), 32'd0);
      check("t1_busy", 32'(bus_busy), 32'd1);
      dma_req = 8'h00;
      step();
      check("t1_release", 32'(grant), 32'h00);
      step();
      check("t1_gap", 32'(grant), 32'h00);
      step();

      // Masters 0 and 2 alternate, with two zero-grant cycles between owners.
      apply_reset();
      dma_req = 8'h05;
      wait_grant(8);
      for (int n = 0; n < 4; n++) begin
         check("t2_seq", 32'(grant), (n % 2 == 0) ? 32'h01 : 32'h04);
         request = 1'b1;
         ready   = 1'b1;
         step();
         request = 1'b0;
         ready   = 1'b0;
         for (int k = 0; k < 10 && grant != 8'd0; k++) step();
         zeros = 0;
         for (int k = 0; k < 10 && grant == 8'd0; k++) begin
            zeros++;
            step();
         end
         check("t2_gap_cycles", 32'(zeros >= 2), 32'd1);
      end

      // Preemption: master 1 owns, master 5 joins at cycle 2 of ownership.
      apply_reset();
      dma_req = 8'h02;
      step();
      check("t4_grant1", 32'(grant), 32'h02);
      step();
      dma_req = 8'h22;
      step();
      step();
      check("t4_still1", 32'(grant), 32'h02);
      step();
      check("t4_preempt", 32'(grant), 32'h00);
      step();
      check("t4_gap", 32'(grant), 32'h00);
      step();
      check("t4_grant5", 32'(grant), 32'h20);

      // Master 2 drops its request mid-transaction and keeps the grant.
      dma_req = 8'h04;
      step();
      step();
      step();
      check("t5_grant2", 32'(grant), 32'h04);
      dma_req = 8'h00;
      request = 1'b1;
      ready   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t5_hold", 32'(grant), 32'h04);
      end
      ready = 1'b1;
      step();
      check("t5_ready", 32'(grant), 32'h04);
      request = 1'b0;
      ready   = 1'b0;
      step();
      check("t5_release", 32'(grant), 32'h00);
      step();
      step();

      // Timeout: master 3 stalls, and master 6 wins the next arbitration.
      dma_req = 8'h08;
      step();
      check("t3_grant3", 32'(grant), 32'h08);
      dma_req = 8'h48;
      request = 1'b1;
      ready   = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 15) check("t3_before_to", 32'(grant), 32'h08);
      end
      check("t3_abort_grant", 32'(grant), 32'h00);
      check("t3_bus_error", 32'(bus_error), 32'd1);
      check("t3_err_owner", 32'(err_owner), 32'd3);
      request = 1'b0;
      step();
      check("t3_err_pulse", 32'(bus_error), 32'd0);
      step();
      check("t3_next", 32'(grant), 32'h40);

      // Asynchronous reset during master 4's transaction.
      dma_req = 8'h10;
      step();
      step();
      step();
      check("t6_grant4", 32'(grant), 32'h10);
      request = 1'b1;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_async_grant", 32'(grant), 32'h00);
      check("t6_async_busy", 32'(bus_busy), 32'd0);
      check("t6_async_err", 32'(err_owner), 32'd0);
      request = 1'b0;
      dma_req = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("t6_first", 32'(grant), 32'h01);

      // Randomized phase: mixed, stall-heavy and idle-heavy episodes.
      mode = 0;
      for (int c = 0; c < 1200; c++) begin
         if (c % 60 == 0) mode = $urandom_range(0, 2);
         if ($urandom_range(0, 4) == 0) dma_req = 8'($urandom) & 8'($urandom);
         case (mode)
            0: begin
               request = 1'($urandom_range(0, 1));
               ready   = 1'($urandom_range(0, 1));
            end
            1: begin
               request = ($urandom_range(0, 19) != 0);
               ready   = ($urandom_range(0, 24) == 0);
            end
            default: begin
               request = ($urandom_range(0, 4) == 0);
               ready   = 1'($urandom_range(0, 1));
            end
         endcase
         step();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter and bus watchdog for the shared 32-bit system bus.
- Takes the 8 DMA request lines from the bus masters and issues one-hot grants.
- Never revokes a grant mid-transaction, i.e. while request is high.
- Forces a turnaround gap between owners, preempts long holders, and aborts transactions whose slave never returns ready.

Parameters:
- TIMEOUT, 16: cycles with request=1 and ready=0 before the transaction is aborted; legal range 2..255.
- HOLD_MAX, 64: cycles an owner may hold the bus before it is preempted, when other masters are waiting; legal range 1..255.

Ports:
- clk  input  1  bus clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dma_req  input  8  bus request from masters; bit i belongs to master i; level-sensitive.
- request  input  1  bus transaction strobe, driven by the granted master.
- ready  input  1  transaction complete, driven by the addressed slave.
- grant  output  8  one-hot bus grant, or all zero; registered.
- owner  output  3  index of the current owner; valid only while bus_busy=1.
- bus_busy  output  1  high while in OWNED.
- bus_error  output  1  one-cycle pulse when a transaction is aborted on timeout.
- err_owner  output  3  index of the master aborted by the last timeout; sticky.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; grant, owner, bus_busy, bus_error, err_owner all 0.
  - last_owner=7, so master 0 has top priority after reset.
  - hold_cnt=0, wd_cnt=0.
- States: IDLE, OWNED, GAP, ERROR. All outputs are registered.
- IDLE:
  - grant=0.
  - If dma_req!=0 at an edge, select the first set bit searching last_owner+1, last_owner+2, ... mod 8.
  - On that same edge: grant[sel]=1, owner=sel, last_owner=sel, hold_cnt=0, wd_cnt=0, state→OWNED.
  - Latency: grant becomes visible on the first edge at which dma_req is sampled high.
  - request/ready are ignored in IDLE.
- OWNED (bus_busy=1, grant held constant):
  - hold_cnt increments each cycle, saturating at 255.
  - wd_cnt increments when request=1 and ready=0; it clears to 0 when ready=1 or request=0.
- OWNED exits, in priority order:
  1. Timeout: request=1, ready=0 and wd_cnt==TIMEOUT-1 → ERROR. grant=0, bus_error=1, err_owner=owner.
  2. Release: dma_req[owner]=0 and request=0 → GAP, grant=0.
  3. Preempt: hold_cnt>=HOLD_MAX-1, (dma_req & ~grant)!=0, and request=0 → GAP, grant=0.
  4. Otherwise stay in OWNED.
- If dma_req[owner] drops while request=1, the grant is kept until request=0. A transaction is never cut except by timeout.
- GAP: exactly one cycle with grant=0 (tristate turnaround), then → IDLE.
- ERROR: exactly one cycle. bus_error=1 in this cycle only, grant=0, then → IDLE. bus_error returns to 0 on the next edge.
- Minimum owner-to-owner gap: 2 cycles with all grants zero (GAP or ERROR, then IDLE).
- Fairness: an aborted or released owner is lowest priority on the next arbitration, because last_owner=owner.
- A master holding dma_req high after release or abort is re-granted only if no other bit is set.
- Simultaneous events:
  - Timeout and release in the same cycle cannot coincide (timeout requires request=1).
  - Preempt and release in the same cycle both go to GAP; the result is identical.
- Invariants: grant is always zero or one-hot; owner==index of the set grant bit whenever bus_busy=1.
- Reset mid-transaction: outputs clear immediately (async). The first arbitration after reset release starts from master 0.

Test Plan:
- Reset, then dma_req=8'h01 → grant=8'h01 one edge later, owner=0, bus_busy=1. Drop dma_req with request=0 → grant=0 next edge; GAP then IDLE.
- dma_req=8'h05 held constant, each owner releasing after one request/ready transaction → grant sequence 01, 04, 01, 04. At least 2 zero-grant cycles between owners.
- Master 3 granted; request=1 with ready never asserted; TIMEOUT=16 → grant drops on the 16th request-high cycle edge. bus_error is high for exactly 1 cycle, err_owner=3. The next grant goes to any other pending master before master 3.
- HOLD_MAX=4; master 1 owns the bus with dma_req held; master 5 requests at cycle 2 of ownership; request=0 → master 1 loses the grant after 4 OWNED cycles, and grant=8'h20 follows 2 cycles later.
- Master 2 drops dma_req while request=1; ready asserts 3 cycles later and request falls → grant held through the transaction, then released only after request=0.
- Assert rst_n=0 mid-transaction with grant=8'h10 → grant, bus_busy and err_owner go to 0 without a clock edge. After release, dma_req=8'hFF → grant=8'h01 first.
